if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Fetch-request sequencer for the IF stage. It takes a PC from PREIF, issues a single-outstanding read on the CPU instruction bus, and captures the returned word into a one-entry output buffer. It presents {PC, instruction, exception} to ID with a valid/allowin handshake. It also handles IF flushes, including discarding a response already in flight, so ID never sees stale instructions.

## Interface
Parameters:
- ADDR_W, 32, PC / bus address width
- DATA_W, 32, instruction width
- CNT_W, 16, width of the discard statistics counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc_valid  in  1  PREIF offers a PC
- pc  in  ADDR_W  offered PC
- pc_ready  out  1  block accepts the PC this cycle
- flush  in  1  IF flush / redirect; kills everything held or in flight
- ibus_req  out  1  address-phase request
- ibus_addr  out  ADDR_W  request address, the latched PC
- ibus_addr_ok  in  1  address phase accepted this cycle
- ibus_data_ok  in  1  read data valid this cycle
- ibus_rdata  in  DATA_W  read data
- out_valid  out  1  buffer holds an instruction for ID
- id_allowin  in  1  ID consumes the buffer this cycle
- out_pc  out  ADDR_W  PC of the buffered instruction
- out_instr  out  DATA_W  buffered instruction
- out_adel  out  1  fetch address error; out_instr = 0
- discard_cnt  out  CNT_W  saturating count of discarded responses

## Operation
The block is a state machine with states IDLE, REQ, WAIT, FULL and DROP.

- **Acceptance.** `pc_ready = !rst && !flush && (state==IDLE || (state==FULL && id_allowin))`. A PC is accepted when `pc_valid && pc_ready`, and is then latched into pc_q.
- **IDLE.** On accept with pc[1:0]==0, go to REQ. On accept with pc[1:0]!=0, go directly to FULL with out_adel=1 and out_instr=0; no bus access is made.
- **REQ.** ibus_req=1 and ibus_addr=pc_q.
  - ibus_addr_ok → WAIT.
  - flush && !ibus_addr_ok → IDLE; the request is withdrawn, which the bus permits before acceptance.
  - flush && ibus_addr_ok → DROP.
- **WAIT.**
  - ibus_data_ok && !flush → capture ibus_rdata, go to FULL.
  - flush && ibus_data_ok → drop the data, count it, go to IDLE.
  - flush && !ibus_data_ok → DROP.
- **FULL.** out_valid=1.
  - id_allowin && !flush → the entry leaves; go to REQ, FULL(adel) or IDLE according to the same-cycle accept.
  - flush → the entry is dropped; go to IDLE. A same-cycle id_allowin is ignored.
- **DROP.** ibus_req=0. Ignore flush. On ibus_data_ok, discard the data, increment discard_cnt, go to IDLE.
- **Outstanding limit.** At most one address phase is outstanding. ibus_req is never asserted in WAIT or DROP.
- **Stability.** ibus_addr is held stable while ibus_req=1 and not yet accepted. out_pc, out_instr and out_adel are stable while out_valid=1 and !id_allowin.
- **discard_cnt.** Saturates at all-ones and never wraps.

## Timing
- **Reset.** All of these are cleared together by the synchronous reset:
  - state=IDLE
  - pc_q=0, out_pc=0, out_instr=0
  - out_adel=0, out_valid=0, ibus_req=0, discard_cnt=0
  - pc_ready=0 while rst=1
  
  Reset mid-transaction goes straight to IDLE. A bus response arriving after reset is outside this block's contract: the bus is reset together with it.
- **Latency.**
  - Accept in cycle 0 → ibus_req in cycle 1.
  - With addr_ok in cycle 1 and data_ok in cycle 2, out_valid is seen in cycle 3.
  - Minimum of 3 cycles from PC accept to out_valid.
  - An address-error PC gives out_valid in cycle 1.
- **Throughput.** One instruction per 3 cycles at best (no overlap, single outstanding).
- **Flush.** Flush in any cycle means out_valid=0 in the next cycle. The first post-flush PC can be accepted:
  - in the cycle after flush from IDLE, REQ (withdrawn) or FULL;
  - only after the in-flight response is drained from DROP.
- **Simultaneous events.**
  - flush has priority over id_allowin, ibus_data_ok and pc_valid.
  - ibus_data_ok in the same cycle as ibus_addr_ok from REQ is not possible on this bus; data_ok is ignored outside WAIT and DROP.

## Structure
- **Shared package (cpu defines).**
  - `if_fetch_state_t` enum (IDLE, REQ, WAIT, FULL, DROP)
  - constant `IF_NOP_INSTR` = 32'h0000_0000, used for out_instr on address error
- **Sub-module `if_out_buf`.** Natural home for the one-entry buffer: out_valid/pc/instr/adel registers with load, pop and kill. The controller FSM and discard counter stay in `if_fetch_ctrl`.

## Test plan
- **Single fetch.** pc=0xBFC0_0000, addr_ok on the first REQ cycle, data_ok one cycle later with 0x2408_0001, id_allowin=1 → out_valid in cycle 3 with out_pc=0xBFC0_0000, out_instr=0x2408_0001, then IDLE.
- **ID stall.** Same as single fetch but id_allowin=0 for 5 cycles → outputs held stable for 5 cycles, pc_ready=0 and ibus_req=0 throughout. Back-to-back pop+accept of 0xBFC0_0004 in the release cycle → ibus_req the next cycle.
- **Flush while in flight.** Flush in WAIT without data_ok; data_ok 0xDEAD_BEEF arrives 2 cycles later → never presented on out_valid, discard_cnt=1, pc_ready=1 the cycle after the data.
- **Flush colliding with acceptance.** Flush in REQ with addr_ok=0 → immediate IDLE and no data expected. Flush in REQ with addr_ok=1 → DROP and discard_cnt increments on the response.
- **Address error.** pc=0xBFC0_0002 → ibus_req never asserts; the next cycle out_valid=1, out_adel=1, out_instr=0.
- **Reset and saturation.** rst asserted in FULL → next cycle out_valid=0, discard_cnt=0. Separately, with discard_cnt preloaded via 65535 flush-discards, one more discard → discard_cnt stays 0xFFFF.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// rtl/if_fetch_ctrl_pkg.sv - shared IF-stage fetch types and constants
package if_fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    FULL = 3'd3,
    DROP = 3'd4
  } if_fetch_state_t;

  localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_out_buf.sv
// rtl/if_out_buf.sv - one-entry IF output buffer presented to ID
module if_out_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              pop,
  input  logic              kill,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [DATA_W-1:0] load_instr,
  input  logic              load_adel,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic              out_adel
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              adel_q, adel_d;

  // kill beats load beats pop; a load in the pop cycle refills the entry
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    adel_d  = adel_q;
    if (kill) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
      adel_d  = load_adel;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      adel_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      adel_q  <= adel_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign out_adel  = adel_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage fetch sequencer with single-outstanding bus read
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_ready,
  input  logic              flush,
  output logic              ibus_req,
  output logic [ADDR_W-1:0] ibus_addr,
  input  logic              ibus_addr_ok,
  input  logic              ibus_data_ok,
  input  logic [DATA_W-1:0] ibus_rdata,
  output logic              out_valid,
  input  logic              id_allowin,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic              out_adel,
  output logic [CNT_W-1:0]  discard_cnt
);

  if_fetch_state_t   state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pc_accept;
  logic              pc_misaligned;
  logic              discard_hit;
  logic              buf_load;
  logic              buf_pop;
  logic [ADDR_W-1:0] buf_load_pc;
  logic [DATA_W-1:0] buf_load_instr;
  logic              buf_load_adel;

  assign pc_ready      = !rst && !flush &&
                         (state_q == IDLE || (state_q == FULL && id_allowin));
  assign pc_accept     = pc_valid && pc_ready;
  assign pc_misaligned = (pc[1:0] != 2'b00);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_accept ? pc : pc_q;
    discard_hit    = 1'b0;
    buf_pop        = 1'b0;
    buf_load       = 1'b0;
    buf_load_pc    = pc;
    buf_load_instr = DATA_W'(IF_NOP_INSTR);
    buf_load_adel  = 1'b1;
    // misaligned PCs skip the bus and land in the buffer as an address error
    if (pc_accept && pc_misaligned) buf_load = 1'b1;
    case (state_q)
      IDLE: if (pc_accept) state_d = pc_misaligned ? FULL : REQ;
      REQ: begin
        if (flush)             state_d = ibus_addr_ok ? DROP : IDLE;
        else if (ibus_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (flush) begin
          discard_hit = ibus_data_ok;
          state_d     = ibus_data_ok ? IDLE : DROP;
        end else if (ibus_data_ok) begin
          state_d        = FULL;
          buf_load       = 1'b1;
          buf_load_pc    = pc_q;
          buf_load_instr = ibus_rdata;
          buf_load_adel  = 1'b0;
        end
      end
      FULL: begin
        if (flush) begin
          state_d = IDLE;
        end else if (id_allowin) begin
          buf_pop = 1'b1;
          if (pc_accept) state_d = pc_misaligned ? FULL : REQ;
          else           state_d = IDLE;
        end
      end
      DROP: begin
        if (ibus_data_ok) begin
          discard_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (discard_hit && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ibus_req    = (state_q == REQ);
  assign ibus_addr   = pc_q;
  assign discard_cnt = cnt_q;

  if_out_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .pop        (buf_pop),
    .kill       (flush),
    .load_pc    (buf_load_pc),
    .load_instr (buf_load_instr),
    .load_adel  (buf_load_adel),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_adel   (out_adel)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pc_valid, flush, ibus_addr_ok, ibus_data_ok, id_allowin;
  logic [31:0] pc, ibus_rdata;

  logic        pc_ready, ibus_req, out_valid, out_adel;
  logic [31:0] ibus_addr, out_pc, out_instr;
  logic [15:0] discard_cnt;

  logic        s_pc_ready, s_ibus_req, s_out_valid, s_out_adel;
  logic [31:0] s_ibus_addr, s_out_pc, s_out_instr;
  logic [3:0]  s_discard_cnt;

  if_fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready),
    .flush(flush), .ibus_req(ibus_req), .ibus_addr(ibus_addr),
    .ibus_addr_ok(ibus_addr_ok), .ibus_data_ok(ibus_data_ok), .ibus_rdata(ibus_rdata),
    .out_valid(out_valid), .id_allowin(id_allowin), .out_pc(out_pc),
    .out_instr(out_instr), .out_adel(out_adel), .discard_cnt(discard_cnt)
  );

  if_fetch_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .pc_ready(s_pc_ready),
    .flush(flush), .ibus_req(s_ibus_req), .ibus_addr(s_ibus_addr),
    .ibus_addr_ok(ibus_addr_ok), .ibus_data_ok(ibus_data_ok), .ibus_rdata(ibus_rdata),
    .out_valid(s_out_valid), .id_allowin(id_allowin), .out_pc(s_out_pc),
    .out_instr(s_out_instr), .out_adel(s_out_adel), .discard_cnt(s_discard_cnt)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Transaction-level model: a pending address, an in-flight read, and a held entry
  bit          m_req, m_inf, m_doom, m_full, m_adel;
  logic [31:0] m_req_addr, m_inf_pc, m_out_pc, m_out_instr;
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    return !rst && !flush && ((!m_req && !m_inf && !m_full) || (m_full && id_allowin));
  endfunction

  task automatic model_step(input logic er);
    bit old_req, old_inf, old_full;
    if (rst) begin
      m_req = 0; m_inf = 0; m_doom = 0; m_full = 0; m_cnt = 0;
      return;
    end
    old_req = m_req; old_inf = m_inf; old_full = m_full;
    if (flush) begin
      m_full = 0;
      if (old_inf) begin
        if (ibus_data_ok) begin m_inf = 0; m_cnt++; end
        else m_doom = 1;
      end
      if (old_req) begin
        m_req = 0;
        if (ibus_addr_ok) begin m_inf = 1; m_doom = 1; end
      end
    end else begin
      if (old_inf && ibus_data_ok) begin
        m_inf = 0;
        if (m_doom) m_cnt++;
        else begin
          m_full = 1; m_out_pc = m_inf_pc; m_out_instr = ibus_rdata; m_adel = 0;
        end
      end
      if (old_req && ibus_addr_ok) begin
        m_req = 0; m_inf = 1; m_doom = 0; m_inf_pc = m_req_addr;
      end
      if (old_full && id_allowin) m_full = 0;
      if (pc_valid && er) begin
        if (pc[1:0] != 2'b00) begin
          m_full = 1; m_out_pc = pc; m_out_instr = 32'h0; m_adel = 1;
        end else begin
          m_req = 1; m_req_addr = pc;
        end
      end
    end
  endtask

  // Per-cycle compare of both instances against the model, then advance
  task automatic tick();
    logic er;
    #1;
    er = exp_ready();
    chk("pc_ready", pc_ready, er);
    chk("s_pc_ready", s_pc_ready, er);
    chk("ibus_req", ibus_req, m_req);
    chk("s_ibus_req", s_ibus_req, m_req);
    if (m_req) begin
      chk("ibus_addr", ibus_addr, m_req_addr);
      chk("s_ibus_addr", s_ibus_addr, m_req_addr);
    end
    chk("out_valid", out_valid, m_full);
    chk("s_out_valid", s_out_valid, m_full);
    if (m_full) begin
      chk("out_pc", out_pc, m_out_pc);
      chk("out_instr", out_instr, m_out_instr);
      chk("out_adel", out_adel, m_adel);
      chk("s_out_pc", s_out_pc, m_out_pc);
      chk("s_out_instr", s_out_instr, m_out_instr);
      chk("s_out_adel", s_out_adel, m_adel);
    end
    chk("discard_cnt", discard_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
    chk("s_discard_cnt", s_discard_cnt, (m_cnt > 15) ? 15 : m_cnt);
    model_step(er);
    @(negedge clk);
  endtask

  task automatic drive(input logic pv, input logic [31:0] p, input logic ao,
                       input logic dok, input logic [31:0] rd, input logic ia,
                       input logic fl);
    pc_valid = pv; pc = p; ibus_addr_ok = ao; ibus_data_ok = dok;
    ibus_rdata = rd; id_allowin = ia; flush = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    #1;
    chk("rst_pc_ready", pc_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ibus_req", ibus_req, 0);
    chk("rst_discard", discard_cnt, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_adel", out_adel, 0);
    rst = 1'b0;

    // single fetch
    drive(1, 32'hBFC0_0000, 0, 0, 0, 1, 0); #1 chk("t1_ready", pc_ready, 1); tick();
    drive(0, 0, 1, 0, 0, 1, 0); #1 chk("t1_req", ibus_req, 1);
    chk("t1_addr", ibus_addr, 32'hBFC0_0000); tick();
    drive(0, 0, 0, 1, 32'h2408_0001, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 0); #1 chk("t1_valid", out_valid, 1);
    chk("t1_pc", out_pc, 32'hBFC0_0000); chk("t1_instr", out_instr, 32'h2408_0001); tick();
    #1 chk("t1_idle_valid", out_valid, 0); chk("t1_idle_ready", pc_ready, 1);

    // ID stall, then pop and accept in the same cycle
    drive(1, 32'hBFC0_0000, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 32'h1111_2222, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'hBFC0_0004, 0, 0, 0, 0, 0); #1
      chk("t2_valid", out_valid, 1); chk("t2_instr", out_instr, 32'h1111_2222);
      chk("t2_pc", out_pc, 32'hBFC0_0000); chk("t2_ready", pc_ready, 0);
      chk("t2_req", ibus_req, 0); tick();
    end
    drive(1, 32'hBFC0_0004, 0, 0, 0, 1, 0); #1 chk("t2_rel_ready", pc_ready, 1); tick();
    drive(0, 0, 1, 0, 0, 1, 0); #1 chk("t2_req2", ibus_req, 1);
    chk("t2_addr2", ibus_addr, 32'hBFC0_0004); tick();
    drive(0, 0, 0, 1, 32'h3C1D_A000, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 0); #1 chk("t2_instr2", out_instr, 32'h3C1D_A000); tick();

    // flush while in flight; response arrives two cycles later
    drive(1, 32'hBFC0_0008, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 1, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 1, 0); #1 chk("t3_drop_ready", pc_ready, 0); tick();
    drive(0, 0, 0, 1, 32'hDEAD_BEEF, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 0); #1 chk("t3_cnt", discard_cnt, 1);
    chk("t3_valid", out_valid, 0); chk("t3_ready", pc_ready, 1); tick();

    // flush in REQ without, then with, address acceptance
    drive(1, 32'hBFC0_000C, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 1); #1 chk("t4_req", ibus_req, 1); tick();
    drive(0, 0, 0, 0, 0, 1, 0); #1 chk("t4_ready", pc_ready, 1);
    chk("t4_noreq", ibus_req, 0); tick();
    drive(1, 32'hBFC0_0010, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 1, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 1, 0); #1 chk("t4_drop_ready", pc_ready, 0); tick();
    drive(0, 0, 0, 1, 32'h1234_5678, 1, 0); tick();
    #1 chk("t4_cnt", discard_cnt, 2);

    // address error
    drive(1, 32'hBFC0_0002, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); #1 chk("t5_req", ibus_req, 0);
    chk("t5_valid", out_valid, 1); chk("t5_adel", out_adel, 1);
    chk("t5_instr", out_instr, 0); chk("t5_pc", out_pc, 32'hBFC0_0002); tick();
    drive(0, 0, 0, 0, 0, 1, 0); tick();

    // reset while FULL
    drive(1, 32'hBFC0_0006, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); rst = 1'b1; #1 chk("t6_ready", pc_ready, 0); tick();
    rst = 1'b0; #1 chk("t6_valid", out_valid, 0); chk("t6_cnt", discard_cnt, 0);

    // twenty discards: narrow counter saturates, wide one keeps counting
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h0000_1000 + 32'(i * 4), 0, 0, 0, 1, 0); tick();
      drive(0, 0, 1, 0, 0, 1, 1); tick();
      drive(0, 0, 0, 1, $urandom, 1, 0); tick();
    end
    #1 chk("t7_cnt", discard_cnt, 20); chk("t7_sat", s_discard_cnt, 4'hF);
    drive(0, 0, 0, 0, 0, 1, 0); tick();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] p;
      p = $urandom;
      if ($urandom_range(7) != 0) p[1:0] = 2'b00;
      drive($urandom_range(9) < 7, p, $urandom_range(1) == 1,
            m_inf && ($urandom_range(9) < 4), $urandom,
            $urandom_range(9) < 6, $urandom_range(11) == 0);
      rst = ($urandom_range(499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
